// File: rtl/muldiv_arbiter.sv
// Two-requester front end for one shared multiply/divide array.
// A round-robin grant picks a requester. Its operands are registered, and the
// array is given SETTLE_CYCLES edges to settle. The result is then held on
// the shared response bus until the owning requester takes it.
// Optional macro MULDIV_DIVZERO_CHECK_EN makes a divide by zero return a fixed
// error response after one edge and raise Rsp_Err.

module multiplier_divider #(
  parameter int DEVIDENT_LENGTH = 6,
  parameter int DIVISOR_LENGTH  = 3
) (
  input  logic [DEVIDENT_LENGTH-1:0] oper_a,
  input  logic [DIVISOR_LENGTH-1:0]  oper_b,
  input  logic [DIVISOR_LENGTH-1:0]  oper_d,
  input  logic                       div_n_mul,
  output logic [DEVIDENT_LENGTH-1:0] result,
  output logic [DIVISOR_LENGTH-1:0]  remainder
);

  logic [DIVISOR_LENGTH:0]    part;
  logic [DEVIDENT_LENGTH-1:0] quot;
  logic [DEVIDENT_LENGTH-1:0] prod;

  // Restoring division, one compare/subtract row per dividend bit.
  // A zero divisor gives an all-ones quotient and the low dividend bits as remainder.
  always_comb begin
    part = '0;
    quot = '0;
    for (int i = DEVIDENT_LENGTH - 1; i >= 0; i--) begin
      part = {part[DIVISOR_LENGTH-1:0], oper_a[i]};
      if (part >= {1'b0, oper_d}) begin
        part    = part - {1'b0, oper_d};
        quot[i] = 1'b1;
      end
    end
  end

  assign prod      = oper_a * DEVIDENT_LENGTH'(oper_b);
  assign result    = div_n_mul ? quot : prod;
  assign remainder = div_n_mul ? part[DIVISOR_LENGTH-1:0] : '0;

endmodule

module muldiv_arbiter #(
  parameter int DEVIDENT_LENGTH = 6,
  parameter int DIVISOR_LENGTH  = 3,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       Req0_Valid,
  output logic                       Req0_Ready,
  input  logic [DEVIDENT_LENGTH-1:0] Req0_OperA,
  input  logic [DIVISOR_LENGTH-1:0]  Req0_OperB,
  input  logic [DIVISOR_LENGTH-1:0]  Req0_OperD,
  input  logic                       Req0_Div_nMul,
  input  logic                       Req1_Valid,
  output logic                       Req1_Ready,
  input  logic [DEVIDENT_LENGTH-1:0] Req1_OperA,
  input  logic [DIVISOR_LENGTH-1:0]  Req1_OperB,
  input  logic [DIVISOR_LENGTH-1:0]  Req1_OperD,
  input  logic                       Req1_Div_nMul,
  output logic                       Rsp0_Valid,
  input  logic                       Rsp0_Ready,
  output logic                       Rsp1_Valid,
  input  logic                       Rsp1_Ready,
  output logic [DEVIDENT_LENGTH-1:0] Rsp_Result,
  output logic [DIVISOR_LENGTH-1:0]  Rsp_Remainder,
  output logic                       Rsp_Err,
  output logic                       Busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       owner_q, owner_d;
  logic                       last_q, last_d;
  logic [DEVIDENT_LENGTH-1:0] oper_a_q, oper_a_d;
  logic [DIVISOR_LENGTH-1:0]  oper_b_q, oper_b_d;
  logic [DIVISOR_LENGTH-1:0]  oper_d_q, oper_d_d;
  logic                       div_q, div_d;
  logic [DEVIDENT_LENGTH-1:0] result_q, result_d;
  logic [DIVISOR_LENGTH-1:0]  rem_q, rem_d;
`ifdef MULDIV_DIVZERO_CHECK_EN
  logic                       err_q, err_d;
`endif
  logic                       grant0, grant1;
  logic [DEVIDENT_LENGTH-1:0] arr_result;
  logic [DIVISOR_LENGTH-1:0]  arr_rem;

  multiplier_divider #(
    .DEVIDENT_LENGTH(DEVIDENT_LENGTH),
    .DIVISOR_LENGTH (DIVISOR_LENGTH)
  ) u_array (
    .oper_a   (oper_a_q),
    .oper_b   (oper_b_q),
    .oper_d   (oper_d_q),
    .div_n_mul(div_q),
    .result   (arr_result),
    .remainder(arr_rem)
  );

  // Round-robin grant; last_q=1 means requester 1 was served last, so 0 wins a tie.
  always_comb begin
    grant1     = Req1_Valid && (!Req0_Valid || !last_q);
    grant0     = Req0_Valid && !grant1;
    Req0_Ready = (state_q == IDLE) && grant0;
    Req1_Ready = (state_q == IDLE) && grant1;
  end

  // Next-state: capture on accept, count down the settle window, hold the response.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    oper_a_d = oper_a_q;
    oper_b_d = oper_b_q;
    oper_d_d = oper_d_q;
    div_d    = div_q;
    result_d = result_q;
    rem_d    = rem_q;
`ifdef MULDIV_DIVZERO_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (Req0_Ready || Req1_Ready) begin
          owner_d  = Req1_Ready;
          oper_a_d = Req1_Ready ? Req1_OperA    : Req0_OperA;
          oper_b_d = Req1_Ready ? Req1_OperB    : Req0_OperB;
          oper_d_d = Req1_Ready ? Req1_OperD    : Req0_OperD;
          div_d    = Req1_Ready ? Req1_Div_nMul : Req0_Div_nMul;
          cnt_d    = CNT_LOAD;
          state_d  = BUSY;
`ifdef MULDIV_DIVZERO_CHECK_EN
          // No settle time needed for the fixed error response: one edge only.
          if (div_d && (oper_d_d == '0)) cnt_d = '0;
`endif
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          result_d = arr_result;
          rem_d    = div_q ? arr_rem : '0;
          state_d  = RESP;
`ifdef MULDIV_DIVZERO_CHECK_EN
          err_d    = 1'b0;
          if (div_q && (oper_d_q == '0)) begin
            result_d = '1;
            rem_d    = oper_a_q[DIVISOR_LENGTH-1:0];
            err_d    = 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if ((!owner_q && Rsp0_Ready) || (owner_q && Rsp1_Ready)) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      oper_a_q <= '0;
      oper_b_q <= '0;
      oper_d_q <= '0;
      div_q    <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
`ifdef MULDIV_DIVZERO_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      oper_a_q <= oper_a_d;
      oper_b_q <= oper_b_d;
      oper_d_q <= oper_d_d;
      div_q    <= div_d;
      result_q <= result_d;
      rem_q    <= rem_d;
`ifdef MULDIV_DIVZERO_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign Rsp0_Valid    = (state_q == RESP) && !owner_q;
  assign Rsp1_Valid    = (state_q == RESP) && owner_q;
  assign Rsp_Result    = result_q;
  assign Rsp_Remainder = rem_q;
  assign Busy          = (state_q != IDLE);
`ifdef MULDIV_DIVZERO_CHECK_EN
  assign Rsp_Err       = err_q;
`else
  assign Rsp_Err       = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Bench for muldiv_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level model.

module tb_muldiv_arbiter;

  localparam int DL     = 6;
  localparam int DVL    = 3;
  localparam int SETTLE = 2;
`ifdef MULDIV_DIVZERO_CHECK_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RST;
  logic           Req0_Valid, Req0_Ready, Req0_Div_nMul;
  logic [DL-1:0]  Req0_OperA;
  logic [DVL-1:0] Req0_OperB, Req0_OperD;
  logic           Req1_Valid, Req1_Ready, Req1_Div_nMul;
  logic [DL-1:0]  Req1_OperA;
  logic [DVL-1:0] Req1_OperB, Req1_OperD;
  logic           Rsp0_Valid, Rsp0_Ready, Rsp1_Valid, Rsp1_Ready;
  logic [DL-1:0]  Rsp_Result;
  logic [DVL-1:0] Rsp_Remainder;
  logic           Rsp_Err, Busy;

  logic [DL-1:0]  g_a, g_res;
  logic [DVL-1:0] g_b, g_d, g_rem;
  logic           g_div;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model state
  bit m_active = 1'b0;
  bit m_owner  = 1'b0;
  bit m_last   = 1'b1;
  bit acc0     = 1'b0;
  bit acc1     = 1'b0;
  int m_wait   = 0;
  int m_res    = 0;
  int m_rem    = 0;
  int m_err    = 0;

  always #5 CLK = ~CLK;

  muldiv_arbiter #(
    .DEVIDENT_LENGTH(DL),
    .DIVISOR_LENGTH (DVL),
    .SETTLE_CYCLES  (SETTLE)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Req0_Valid   (Req0_Valid),
    .Req0_Ready   (Req0_Ready),
    .Req0_OperA   (Req0_OperA),
    .Req0_OperB   (Req0_OperB),
    .Req0_OperD   (Req0_OperD),
    .Req0_Div_nMul(Req0_Div_nMul),
    .Req1_Valid   (Req1_Valid),
    .Req1_Ready   (Req1_Ready),
    .Req1_OperA   (Req1_OperA),
    .Req1_OperB   (Req1_OperB),
    .Req1_OperD   (Req1_OperD),
    .Req1_Div_nMul(Req1_Div_nMul),
    .Rsp0_Valid   (Rsp0_Valid),
    .Rsp0_Ready   (Rsp0_Ready),
    .Rsp1_Valid   (Rsp1_Valid),
    .Rsp1_Ready   (Rsp1_Ready),
    .Rsp_Result   (Rsp_Result),
    .Rsp_Remainder(Rsp_Remainder),
    .Rsp_Err      (Rsp_Err),
    .Busy         (Busy)
  );

  multiplier_divider #(
    .DEVIDENT_LENGTH(DL),
    .DIVISOR_LENGTH (DVL)
  ) u_gold (
    .oper_a   (g_a),
    .oper_b   (g_b),
    .oper_d   (g_d),
    .div_n_mul(g_div),
    .result   (g_res),
    .remainder(g_rem)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result of one operation, from plain arithmetic.
  function automatic void golden(input int a, input int b, input int d, input bit div,
                                 output int res, output int rem, output int err,
                                 output int lat);
    lat = SETTLE;
    err = 0;
    if (!div) begin
      res = (a * b) % (1 << DL);
      rem = 0;
    end else if (d == 0) begin
      res = (1 << DL) - 1;
      rem = a % (1 << DVL);
      if (DZ) begin
        err = 1;
        lat = 1;
      end
    end else begin
      res = a / d;
      rem = a % d;
    end
  endfunction

  function automatic bit exp_ready(input bit n);
    if (m_active) return 1'b0;
    if (!n) return Req0_Valid && (!Req1_Valid || m_last);
    return Req1_Valid && (!Req0_Valid || !m_last);
  endfunction

  // Model: one transaction at a time, m_wait edges until its response shows.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_active = 1'b0;
      m_last   = 1'b1;
      m_wait   = 0;
      acc0     = 1'b0;
      acc1     = 1'b0;
    end else begin
      acc0 = exp_ready(1'b0);
      acc1 = exp_ready(1'b1);
      if (m_active) begin
        if (m_wait > 0) m_wait--;
        else if (m_owner ? Rsp1_Ready : Rsp0_Ready) begin
          m_active = 1'b0;
          m_last   = m_owner;
        end
      end else if (acc0 || acc1) begin
        m_owner = acc1;
        if (acc1) golden(Req1_OperA, Req1_OperB, Req1_OperD, Req1_Div_nMul, m_res, m_rem, m_err, m_wait);
        else      golden(Req0_OperA, Req0_OperB, Req0_OperD, Req0_Div_nMul, m_res, m_rem, m_err, m_wait);
        m_active = 1'b1;
      end
    end
  end

  // Compare DUT against the model on every falling edge out of reset.
  always @(negedge CLK) begin
    if (!RST) begin
      chk("busy", Busy, m_active);
      chk("req0_ready", Req0_Ready, exp_ready(1'b0));
      chk("req1_ready", Req1_Ready, exp_ready(1'b1));
      chk("rsp0_valid", Rsp0_Valid, m_active && m_wait == 0 && !m_owner);
      chk("rsp1_valid", Rsp1_Valid, m_active && m_wait == 0 && m_owner);
      if (m_active && m_wait == 0) begin
        chk("rsp_result", Rsp_Result, m_res);
        chk("rsp_remainder", Rsp_Remainder, m_rem);
        chk("rsp_err", Rsp_Err, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input bit n, input bit v, input int a, input int b, input int d, input bit div);
    if (!n) begin
      Req0_Valid = v; Req0_OperA = DL'(a); Req0_OperB = DVL'(b); Req0_OperD = DVL'(d); Req0_Div_nMul = div;
    end else begin
      Req1_Valid = v; Req1_OperA = DL'(a); Req1_OperB = DVL'(b); Req1_OperD = DVL'(d); Req1_Div_nMul = div;
    end
  endtask

  task automatic wait_rsp(input bit n, output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!(n ? Rsp1_Valid : Rsp0_Valid) && edges < 20);
    chk("rsp_valid_seen", n ? Rsp1_Valid : Rsp0_Valid, 1);
  endtask

  initial begin
    int k;
    RST = 1'b1;
    set_req(1'b0, 1'b0, 0, 0, 0, 1'b0);
    set_req(1'b1, 1'b0, 0, 0, 0, 1'b0);
    Rsp0_Ready = 1'b0; Rsp1_Ready = 1'b0;
    g_a = '0; g_b = '0; g_d = '0; g_div = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_busy", Busy, 0);
    chk("reset_req0_ready", Req0_Ready, 0);
    chk("reset_req1_ready", Req1_Ready, 0);
    chk("reset_rsp0_valid", Rsp0_Valid, 0);
    chk("reset_rsp1_valid", Rsp1_Valid, 0);
    chk("reset_result", Rsp_Result, 0);
    chk("reset_remainder", Rsp_Remainder, 0);
    chk("reset_err", Rsp_Err, 0);
    RST = 1'b0;
    tick();

    // Divide 45/6 on requester 0
    set_req(1'b0, 1'b1, 45, 0, 6, 1'b1);
    Rsp0_Ready = 1'b1;
    #1;
    chk("div_req0_ready", Req0_Ready, 1);
    tick();
    set_req(1'b0, 1'b0, 63, 7, 7, 1'b0);
    wait_rsp(1'b0, k);
    chk("div_latency", k, 2);
    chk("div_result", Rsp_Result, 7);
    chk("div_remainder", Rsp_Remainder, 3);
    chk("div_err", Rsp_Err, 0);
    tick();
    chk("div_idle", Busy, 0);

    // Multiply 5*3 on requester 1, against the golden array
    set_req(1'b1, 1'b1, 5, 3, 0, 1'b0);
    Rsp1_Ready = 1'b1;
    g_a = 6'd5; g_b = 3'd3; g_d = 3'd0; g_div = 1'b0;
    tick();
    set_req(1'b1, 1'b0, 0, 0, 0, 1'b0);
    wait_rsp(1'b1, k);
    chk("mul_latency", k, 2);
    chk("mul_result", Rsp_Result, 15);
    chk("mul_golden", Rsp_Result, g_res);
    chk("mul_remainder", Rsp_Remainder, 0);
    chk("mul_rsp0_quiet", Rsp0_Valid, 0);
    tick();

    // Divide by zero
    set_req(1'b0, 1'b1, 21, 0, 0, 1'b1);
    Rsp0_Ready = 1'b1;
    g_a = 6'd21; g_b = 3'd0; g_d = 3'd0; g_div = 1'b1;
    tick();
    set_req(1'b0, 1'b0, 0, 0, 0, 1'b0);
    wait_rsp(1'b0, k);
    chk("dz_latency", k, DZ ? 1 : SETTLE);
    chk("dz_result", Rsp_Result, 63);
    chk("dz_remainder", Rsp_Remainder, 5);
    chk("dz_err", Rsp_Err, DZ);
    chk("dz_golden_result", Rsp_Result, g_res);
    chk("dz_golden_remainder", Rsp_Remainder, g_rem);
    tick();

    // Response stall: 30/4 held while requester 1 waits
    set_req(1'b0, 1'b1, 30, 0, 4, 1'b1);
    Rsp0_Ready = 1'b0;
    Rsp1_Ready = 1'b1;
    tick();
    set_req(1'b0, 1'b0, 0, 0, 0, 1'b0);
    set_req(1'b1, 1'b1, 9, 2, 0, 1'b0);
    wait_rsp(1'b0, k);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp0_valid", Rsp0_Valid, 1);
      chk("stall_result", Rsp_Result, 7);
      chk("stall_remainder", Rsp_Remainder, 2);
      chk("stall_req1_ready", Req1_Ready, 0);
      chk("stall_rsp1_valid", Rsp1_Valid, 0);
      tick();
    end
    Rsp0_Ready = 1'b1;
    tick();
    chk("stall_release_busy", Busy, 0);
    chk("stall_release_rsp0", Rsp0_Valid, 0);
    chk("stall_release_req1_ready", Req1_Ready, 1);
    tick();
    set_req(1'b1, 1'b0, 0, 0, 0, 1'b0);
    wait_rsp(1'b1, k);
    chk("stall_req1_result", Rsp_Result, 18);
    tick();

    // Reset in the middle of a multiply, then a clean divide
    set_req(1'b0, 1'b1, 7, 7, 0, 1'b0);
    tick();
    set_req(1'b0, 1'b0, 0, 0, 0, 1'b0);
    tick();
    RST = 1'b1;
    #1;
    chk("midrst_busy", Busy, 0);
    chk("midrst_rsp0_valid", Rsp0_Valid, 0);
    chk("midrst_rsp1_valid", Rsp1_Valid, 0);
    chk("midrst_req0_ready", Req0_Ready, 0);
    chk("midrst_req1_ready", Req1_Ready, 0);
    chk("midrst_result", Rsp_Result, 0);
    chk("midrst_remainder", Rsp_Remainder, 0);
    chk("midrst_err", Rsp_Err, 0);
    #1;
    RST = 1'b0;
    tick();
    set_req(1'b0, 1'b1, 50, 0, 7, 1'b1);
    Rsp0_Ready = 1'b1;
    tick();
    set_req(1'b0, 1'b0, 0, 0, 0, 1'b0);
    wait_rsp(1'b0, k);
    chk("postrst_latency", k, 2);
    chk("postrst_result", Rsp_Result, 7);
    chk("postrst_remainder", Rsp_Remainder, 1);
    tick();

    // Tie from reset: 0 first, then 1, then 0 again
    RST = 1'b1;
    #2;
    RST = 1'b0;
    tick();
    set_req(1'b0, 1'b1, 2, 3, 0, 1'b0);
    set_req(1'b1, 1'b1, 4, 2, 0, 1'b0);
    Rsp0_Ready = 1'b1;
    Rsp1_Ready = 1'b1;
    #1;
    chk("tie1_req0_ready", Req0_Ready, 1);
    chk("tie1_req1_ready", Req1_Ready, 0);
    tick();
    wait_rsp(1'b0, k);
    chk("tie1_result", Rsp_Result, 6);
    tick();
    chk("tie2_req1_ready", Req1_Ready, 1);
    chk("tie2_req0_ready", Req0_Ready, 0);
    tick();
    wait_rsp(1'b1, k);
    chk("tie2_result", Rsp_Result, 8);
    tick();
    chk("tie3_req0_ready", Req0_Ready, 1);
    chk("tie3_req1_ready", Req1_Ready, 0);
    set_req(1'b0, 1'b0, 0, 0, 0, 1'b0);
    set_req(1'b1, 1'b0, 0, 0, 0, 1'b0);
    repeat (6) tick();

    // Random traffic; a requester holds its request until accepted
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!Req0_Valid || acc0)
        set_req(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 7),
                $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      if (!Req1_Valid || acc1)
        set_req(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 7),
                $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      Rsp0_Ready = ($urandom_range(0, 2) != 0);
      Rsp1_Ready = ($urandom_range(0, 2) != 0);
    end

    set_req(1'b0, 1'b0, 0, 0, 0, 1'b0);
    set_req(1'b1, 1'b0, 0, 0, 0, 1'b0);
    Rsp0_Ready = 1'b1;
    Rsp1_Ready = 1'b1;
    repeat (20) tick();
    chk("final_idle", Busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
